// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared definitions for the memory stage. RV32I load/store
//               funct3 encodings, the LSU state enumeration, and a helper
//               that decodes funct3 into an access size.
// Revision    : 1.0  Initial release
// ============================================================================
package riscv_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } access_size_e;

    // Any funct3 that is not a recognised byte/half encoding is a word access.
    function automatic access_size_e access_size(input logic [2:0] funct3,
                                                 input logic       is_store);
        access_size_e size;
        size = SIZE_W;
        if (is_store) begin
            if (funct3 == F3_SB)      size = SIZE_B;
            else if (funct3 == F3_SH) size = SIZE_H;
        end else begin
            if (funct3 == F3_LB || funct3 == F3_LBU)      size = SIZE_B;
            else if (funct3 == F3_LH || funct3 == F3_LHU) size = SIZE_H;
        end
        return size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Combinational load-data formatter. Selects the addressed
//               byte or halfword from the returned memory word and sign- or
//               zero-extends it according to funct3.
// Revision    : 1.0  Initial release
// Ports       : rdata_i  [31:0] raw memory word
//               funct3_i [2:0]  load funct3
//               offset_i [1:0]  byte offset within the word
//               data_o   [31:0] extended writeback value
// ============================================================================
module load_extract
    import riscv_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata_i[7:0];
        case (offset_i)
            2'd0:    w_byte = rdata_i[7:0];
            2'd1:    w_byte = rdata_i[15:8];
            2'd2:    w_byte = rdata_i[23:16];
            default: w_byte = rdata_i[31:24];
        endcase
        // Halfword accesses are already known to be aligned, so only offset[1] matters.
        w_half = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_LB:   data_o = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  data_o = {24'b0, w_byte};
            F3_LH:   data_o = {{16{w_half[15]}}, w_half};
            F3_LHU:  data_o = {16'b0, w_half};
            default: data_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory stage after the ALU. Non-memory ops pass the ALU
//               result to writeback in one cycle. Loads/stores are checked
//               for alignment, then issued over a req/gnt/rvalid handshake;
//               EX is stalled while an access is outstanding.
// Revision    : 1.0  Initial release
// Ports       : ex_*   instruction from EX (sampled only in IDLE)
//               ex_stall       EX must hold (Moore: state != IDLE)
//               mem_*          single-port data memory handshake
//               wb_*           registered one-cycle writeback pulse
//               misaligned     one-cycle pulse on a misaligned access
// ============================================================================
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    output logic            ex_stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic [XLEN-1:0] wb_data,
    output logic            misaligned
);

    lsu_state_e   state_q;
    logic         we_q;
    logic [31:0]  addr_q;
    logic [2:0]   funct3_q;
    logic [31:0]  wdata_q;
    logic [3:0]   wstrb_q;
    logic [4:0]   rd_q;
    logic         reg_write_q;
    logic         wb_valid_q;
    logic [4:0]   wb_rd_q;
    logic         wb_reg_write_q;
    logic [31:0]  wb_data_q;
    logic         misaligned_q;

    logic         w_is_mem;
    access_size_e w_size;
    logic [1:0]   w_off;
    logic         w_misaligned;
    logic [31:0]  w_wdata;
    logic [3:0]   w_wstrb;
    logic [31:0]  w_load_data;

    // A simultaneous read+write is a store, so the store flag alone picks the decode.
    assign w_is_mem = ex_mem_read | ex_mem_write;
    assign w_size   = access_size(ex_funct3, ex_mem_write);
    assign w_off    = ex_alu_result[1:0];

    always_comb begin
        w_misaligned = 1'b0;
        w_wdata      = ex_store_data;
        w_wstrb      = 4'b1111;
        case (w_size)
            SIZE_B: begin
                w_wdata = {4{ex_store_data[7:0]}};
                w_wstrb = 4'b0001 << w_off;
            end
            SIZE_H: begin
                w_misaligned = w_off[0];
                w_wdata      = {2{ex_store_data[15:0]}};
                w_wstrb      = 4'b0011 << w_off;
            end
            default: begin
                w_misaligned = (w_off != 2'b00);
            end
        endcase
    end

    load_extract u_load_extract (
        .rdata_i  (mem_rdata),
        .funct3_i (funct3_q),
        .offset_i (addr_q[1:0]),
        .data_o   (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            we_q           <= 1'b0;
            addr_q         <= '0;
            funct3_q       <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            rd_q           <= '0;
            reg_write_q    <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
            wb_data_q      <= '0;
            misaligned_q   <= 1'b0;
        end else begin
            // Writeback and misaligned are pulses; clear unless set below.
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
            wb_data_q      <= '0;
            misaligned_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (ex_valid) begin
                        if (!w_is_mem) begin
                            wb_valid_q     <= 1'b1;
                            wb_rd_q        <= ex_rd;
                            wb_reg_write_q <= ex_reg_write;
                            wb_data_q      <= ex_alu_result;
                        end else if (w_misaligned) begin
                            // Retire without touching memory; the faulting address is reported.
                            misaligned_q   <= 1'b1;
                            wb_valid_q     <= 1'b1;
                            wb_rd_q        <= ex_rd;
                            wb_data_q      <= ex_alu_result;
                        end else begin
                            state_q     <= REQ;
                            we_q        <= ex_mem_write;
                            addr_q      <= ex_alu_result;
                            funct3_q    <= ex_funct3;
                            wdata_q     <= ex_mem_write ? w_wdata : '0;
                            wstrb_q     <= ex_mem_write ? w_wstrb : 4'b0000;
                            rd_q        <= ex_rd;
                            reg_write_q <= ex_reg_write;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) state_q <= WAIT;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_q        <= IDLE;
                        wb_valid_q     <= 1'b1;
                        wb_rd_q        <= rd_q;
                        wb_reg_write_q <= we_q ? 1'b0 : reg_write_q;
                        wb_data_q      <= we_q ? '0 : w_load_data;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Request fields are only presented while the request is live.
    assign ex_stall     = (state_q != IDLE);
    assign mem_req      = (state_q == REQ);
    assign mem_we       = mem_req & we_q;
    assign mem_addr     = mem_req ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wdata    = mem_req ? wdata_q : '0;
    assign mem_wstrb    = mem_req ? wstrb_q : 4'b0000;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_data      = wb_data_q;
    assign misaligned   = misaligned_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. Directed scenarios
//               plus randomized accesses checked against a byte-arithmetic
//               reference model and a responsive memory model.
// Revision    : 1.0  Initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid, wb_reg_write, misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_cmp  = 0;
    int n_fail = 0;

    load_store_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_stall(ex_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int model_bytes(input logic [2:0] f3, input bit store);
        case (f3)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd4:    return store ? 4 : 1;
            3'd5:    return store ? 4 : 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [2:0] f3,
                                               input int off);
        int          n;
        logic [31:0] v;
        n = model_bytes(f3, 1'b0);
        v = rdata >> (8 * off);
        if (n == 1) begin
            v = v & 32'h0000_00FF;
            if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (n == 2) begin
            v = v & 32'h0000_FFFF;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] sd, input int n);
        if (n == 1) return {24'b0, sd[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'b0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [3:0] model_wstrb(input int n, input int off);
        int m;
        m = ((1 << n) - 1) << off;
        return m[3:0];
    endfunction

    // ---------------- one instruction through the stage ----------------
    task automatic do_access(input bit rd_f, input bit wr_f, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [4:0] rd, input bit regw,
                             input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                             output logic [31:0] o_wb_data, output logic [31:0] o_addr,
                             output logic [31:0] o_wdata, output logic [3:0] o_wstrb,
                             output logic o_wb_rw, output logic o_misal, output logic o_req);
        bit          is_mem, store, mis;
        int          n, off;
        logic [31:0] exp_addr, exp_wd, exp_data;
        logic [3:0]  exp_ws;
        is_mem   = rd_f | wr_f;
        store    = wr_f;
        n        = model_bytes(f3, store);
        off      = int'(addr[1:0]);
        mis      = is_mem && ((off % n) != 0);
        exp_addr = addr - 32'(off);
        exp_wd   = model_wdata(sdata, n);
        exp_ws   = model_wstrb(n, off);
        exp_data = model_load(rdata, f3, off);
        o_wb_data = 'x; o_addr = '0; o_wdata = '0; o_wstrb = '0;
        o_wb_rw = 1'b0; o_misal = 1'b0; o_req = 1'b0;

        @(negedge clk);
        ex_valid = 1'b1; ex_mem_read = rd_f; ex_mem_write = wr_f; ex_funct3 = f3;
        ex_alu_result = addr; ex_store_data = sdata; ex_rd = rd; ex_reg_write = regw;
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_alu_result = $urandom; ex_store_data = $urandom;

        if (!is_mem || mis) begin
            o_wb_data = wb_data; o_wb_rw = wb_reg_write; o_misal = misaligned; o_req = mem_req;
            n_cmp++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL wb_valid_1cyc: got %b want 1", wb_valid); end
            n_cmp++; if (wb_reg_write !== (mis ? 1'b0 : regw)) begin n_fail++; $display("FAIL wb_reg_write_1cyc: got %b want %b", wb_reg_write, (mis ? 1'b0 : regw)); end
            n_cmp++; if (misaligned !== mis) begin n_fail++; $display("FAIL misaligned: got %b want %b", misaligned, mis); end
            n_cmp++; if (ex_stall !== 1'b0) begin n_fail++; $display("FAIL stall_1cyc: got %b want 0", ex_stall); end
            n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL no_req: got %b want 0", mem_req); end
            if (!is_mem) begin
                n_cmp++; if (wb_data !== addr) begin n_fail++; $display("FAIL passthru_data: got %h want %h", wb_data, addr); end
                n_cmp++; if (wb_rd !== rd) begin n_fail++; $display("FAIL passthru_rd: got %0d want %0d", wb_rd, rd); end
            end
            @(negedge clk);
            n_cmp++; if (wb_valid !== 1'b0 || misaligned !== 1'b0 || wb_data !== 32'h0) begin
                n_fail++; $display("FAIL pulse_end: got v=%b m=%b d=%h want 0/0/0", wb_valid, misaligned, wb_data); end
            n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL no_req_after: got %b want 0", mem_req); end
        end else begin
            for (int k = 0; k <= gnt_dly; k++) begin
                o_req = o_req | mem_req; o_addr = mem_addr; o_wdata = mem_wdata; o_wstrb = mem_wstrb;
                n_cmp++; if (mem_req !== 1'b1 || ex_stall !== 1'b1 || wb_valid !== 1'b0) begin
                    n_fail++; $display("FAIL req_phase: got req=%b stall=%b wbv=%b want 1/1/0", mem_req, ex_stall, wb_valid); end
                n_cmp++; if (mem_we !== store) begin n_fail++; $display("FAIL mem_we: got %b want %b", mem_we, store); end
                n_cmp++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL mem_addr: got %h want %h", mem_addr, exp_addr); end
                if (store) begin
                    n_cmp++; if (mem_wdata !== exp_wd) begin n_fail++; $display("FAIL mem_wdata: got %h want %h", mem_wdata, exp_wd); end
                    n_cmp++; if (mem_wstrb !== exp_ws) begin n_fail++; $display("FAIL mem_wstrb: got %b want %b", mem_wstrb, exp_ws); end
                end
                mem_gnt    = (k == gnt_dly);
                // Stray responses before the grant must be ignored.
                mem_rvalid = (k != gnt_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rdata  = $urandom;
                @(negedge clk);
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            for (int j = 0; j <= rv_dly; j++) begin
                n_cmp++; if (mem_req !== 1'b0 || ex_stall !== 1'b1 || wb_valid !== 1'b0) begin
                    n_fail++; $display("FAIL wait_phase: got req=%b stall=%b wbv=%b want 0/1/0", mem_req, ex_stall, wb_valid); end
                if (j == rv_dly) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
                @(negedge clk);
            end
            mem_rvalid = 1'b0; mem_rdata = $urandom;
            o_wb_data = wb_data; o_wb_rw = wb_reg_write;
            n_cmp++; if (wb_valid !== 1'b1 || ex_stall !== 1'b0) begin
                n_fail++; $display("FAIL mem_done: got wbv=%b stall=%b want 1/0", wb_valid, ex_stall); end
            n_cmp++; if (wb_rd !== rd) begin n_fail++; $display("FAIL mem_wb_rd: got %0d want %0d", wb_rd, rd); end
            n_cmp++; if (wb_reg_write !== (store ? 1'b0 : regw)) begin
                n_fail++; $display("FAIL mem_wb_rw: got %b want %b", wb_reg_write, (store ? 1'b0 : regw)); end
            n_cmp++; if (wb_data !== (store ? 32'h0 : exp_data)) begin
                n_fail++; $display("FAIL mem_wb_data: got %h want %h", wb_data, (store ? 32'h0 : exp_data)); end
            @(negedge clk);
            n_cmp++; if (wb_valid !== 1'b0 || wb_data !== 32'h0 || wb_reg_write !== 1'b0) begin
                n_fail++; $display("FAIL mem_pulse_end: got v=%b d=%h rw=%b want 0/0/0", wb_valid, wb_data, wb_reg_write); end
        end
    endtask

    // ---------------- scenarios ----------------
    logic [31:0] r_data, r_addr, r_wd;
    logic [3:0]  r_ws;
    logic        r_rw, r_mis, r_req;

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++; if ({mem_req, mem_we, ex_stall, wb_valid, misaligned, wb_reg_write} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {mem_req, mem_we, ex_stall, wb_valid, misaligned, wb_reg_write}); end
        n_cmp++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0 || wb_data !== 32'h0 || wb_rd !== 5'h0) begin
            n_fail++; $display("FAIL reset_data: got a=%h wd=%h ws=%b d=%h rd=%0d want zeros", mem_addr, mem_wdata, mem_wstrb, wb_data, wb_rd); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_read = 1'b1; ex_alu_result = 32'h0000_0700;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (mem_req !== 1'b0 || wb_valid !== 1'b0 || ex_stall !== 1'b0) begin
                n_fail++; $display("FAIL idle_quiet: got req=%b wbv=%b stall=%b want 0/0/0", mem_req, wb_valid, ex_stall); end
        end
        ex_mem_read = 1'b0;
    endtask

    task automatic test_passthrough();
        do_access(0, 0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 0, 32'h0,
                  r_data, r_addr, r_wd, r_ws, r_rw, r_mis, r_req);
        n_cmp++; if (r_data !== 32'h0000_1234) begin n_fail++; $display("FAIL tp_passthru: got %h want 00001234", r_data); end
    endtask

    task automatic test_lb_sign();
        do_access(1, 0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1, 2, 1, 32'h80AA_BBCC,
                  r_data, r_addr, r_wd, r_ws, r_rw, r_mis, r_req);
        n_cmp++; if (r_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL tp_lb_addr: got %h want 00000100", r_addr); end
        n_cmp++; if (r_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL tp_lb_data: got %h want ffffff80", r_data); end
    endtask

    task automatic test_lhu();
        do_access(1, 0, 3'b101, 32'h0000_0202, 32'h0, 5'd9, 1, 0, 0, 32'hBEEF_1234,
                  r_data, r_addr, r_wd, r_ws, r_rw, r_mis, r_req);
        n_cmp++; if (r_data !== 32'h0000_BEEF) begin n_fail++; $display("FAIL tp_lhu_data: got %h want 0000beef", r_data); end
    endtask

    task automatic test_sb_sh();
        do_access(0, 1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 5'd3, 1, 1, 0, 32'h0,
                  r_data, r_addr, r_wd, r_ws, r_rw, r_mis, r_req);
        n_cmp++; if (r_wd !== 32'hA5A5_A5A5 || r_ws !== 4'b0010 || r_rw !== 1'b0) begin
            n_fail++; $display("FAIL tp_sb: got wd=%h ws=%b rw=%b want a5a5a5a5/0010/0", r_wd, r_ws, r_rw); end
        do_access(0, 1, 3'b001, 32'h0000_0302, 32'h0000_1234, 5'd4, 1, 0, 2, 32'h0,
                  r_data, r_addr, r_wd, r_ws, r_rw, r_mis, r_req);
        n_cmp++; if (r_wd !== 32'h1234_1234 || r_ws !== 4'b1100 || r_rw !== 1'b0) begin
            n_fail++; $display("FAIL tp_sh: got wd=%h ws=%b rw=%b want 12341234/1100/0", r_wd, r_ws, r_rw); end
    endtask

    task automatic test_misaligned();
        do_access(1, 0, 3'b010, 32'h0000_0402, 32'h0, 5'd11, 1, 0, 0, 32'h0,
                  r_data, r_addr, r_wd, r_ws, r_rw, r_mis, r_req);
        n_cmp++; if (r_mis !== 1'b1 || r_req !== 1'b0 || r_rw !== 1'b0) begin
            n_fail++; $display("FAIL tp_misaligned: got mis=%b req=%b rw=%b want 1/0/0", r_mis, r_req, r_rw); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rdata;
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'b010;
        ex_alu_result = 32'h0000_0600; ex_rd = 5'd12; ex_reg_write = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_read = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        n_cmp++; if (ex_stall !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL rst_in_wait: got stall=%b req=%b want 1/0", ex_stall, mem_req); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || ex_stall !== 1'b0 || wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: got req=%b stall=%b wbv=%b want 0/0/0", mem_req, ex_stall, wb_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        rdata = $urandom;
        do_access(1, 0, 3'b010, 32'h0000_0500, 32'h0, 5'd13, 1, 1, 1, rdata,
                  r_data, r_addr, r_wd, r_ws, r_rw, r_mis, r_req);
        n_cmp++; if (r_data !== rdata || r_addr !== 32'h0000_0500) begin
            n_fail++; $display("FAIL rst_recover_lw: got d=%h a=%h want %h/00000500", r_data, r_addr, rdata); end
    endtask

    task automatic test_random();
        int          kind;
        logic [31:0] addr;
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 3);
            addr = $urandom;
            do_access(kind[0], kind[1], 3'($urandom_range(0, 7)), addr, $urandom,
                      5'($urandom), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                      r_data, r_addr, r_wd, r_ws, r_rw, r_mis, r_req);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = 3'b0;
        ex_alu_result = '0; ex_store_data = '0; ex_rd = '0; ex_reg_write = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        test_reset();
        test_idle();
        test_passthrough();
        test_lb_sign();
        test_lhu();
        test_sb_sh();
        test_misaligned();
        test_reset_mid_access();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
